operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 111 +++++++++++
 tb/tb_operand_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - two-operand capture FSM driven by a synchronised pushbutton
module operand_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             valid,
  output logic [1:0]       state,
  output logic [7:0]       pair_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HAVE_A  = 2'b01,
    READY   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t           cur_state, nxt_state;
  logic             s1, s2, s3;
  logic             load_p, cap;
  logic [WIDTH-1:0] op_a_nxt, op_b_nxt;
  logic             valid_nxt;
  logic [7:0]       cnt_nxt;

  // s1/s2 resolve metastability on the raw button; s3 delays s2 for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= load;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign load_p = s2 & ~s3;
  assign cap    = load_p & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      valid     <= 1'b0;
      pair_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      valid     <= valid_nxt;
      pair_cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    op_a_nxt  = op_a;
    op_b_nxt  = op_b;
    valid_nxt = valid;
    cnt_nxt   = pair_cnt;
    if (clr) begin
      nxt_state = IDLE;
      op_a_nxt  = '0;
      op_b_nxt  = '0;
      valid_nxt = 1'b0;
      cnt_nxt   = 8'd0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (cap) begin
            op_a_nxt  = din;
            nxt_state = HAVE_A;
          end
        end
        HAVE_A: begin
          if (cap) begin
            op_b_nxt  = din;
            valid_nxt = 1'b1;
            cnt_nxt   = pair_cnt + 8'd1;
            nxt_state = READY;
          end
        end
        READY: begin
          if (cap) begin
            op_a_nxt  = din;
            op_b_nxt  = '0;
            valid_nxt = 1'b0;
            nxt_state = HAVE_A;
          end
        end
        default: begin
          // unreachable code 11: recover even while ena is low
          nxt_state = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader
module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic       load;
  logic       clr;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       valid;
  logic [1:0] state;
  logic [7:0] pair_cnt;

  int checks = 0;
  int errors = 0;

  operand_loader #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din      (din),
    .load     (load),
    .clr      (clr),
    .op_a     (op_a),
    .op_b     (op_b),
    .valid    (valid),
    .state    (state),
    .pair_cnt (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // load is sampled at two rising edges; capture lands on the second edge after the first sample
  task automatic pulse_load(input logic [7:0] d);
    @(negedge clk);
    din  = d;
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; din = 8'h00; load = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL reset_op_a got %h exp 00", op_a); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL reset_op_b got %h exp 00", op_b); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got %h exp 00", pair_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pair;
    pulse_load(8'h2A);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL first_state got %b exp 01", state); end
    checks++; if (op_a !== 8'h2A) begin errors++; $display("FAIL first_op_a got %h exp 2a", op_a); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid got %b exp 0", valid); end
    pulse_load(8'h0F);
    checks++; if (op_a !== 8'h2A) begin errors++; $display("FAIL pair_op_a got %h exp 2a", op_a); end
    checks++; if (op_b !== 8'h0F) begin errors++; $display("FAIL pair_op_b got %h exp 0f", op_b); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pair_valid got %b exp 1", valid); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pair_state got %b exp 10", state); end
    checks++; if (pair_cnt !== 8'h01) begin errors++; $display("FAIL pair_cnt got %h exp 01", pair_cnt); end
  endtask

  task automatic test_restart;
    pulse_load(8'h55);
    checks++; if (op_a !== 8'h55) begin errors++; $display("FAIL restart_op_a got %h exp 55", op_a); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL restart_op_b got %h exp 00", op_b); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL restart_valid got %b exp 0", valid); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart_state got %b exp 01", state); end
    checks++; if (pair_cnt !== 8'h01) begin errors++; $display("FAIL restart_cnt got %h exp 01", pair_cnt); end
  endtask

  task automatic test_clr_priority;
    // state HAVE_A with pair_cnt 1; clr coincides with the capture edge
    @(negedge clk);
    din  = 8'h99;
    load = 1'b1;
    repeat (2) @(negedge clk);
    clr  = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_state got %b exp 00", state); end
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL clr_op_a got %h exp 00", op_a); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b exp 0", valid); end
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL clr_cnt got %h exp 00", pair_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clr_discard got %b exp 00", state); end
  endtask

  task automatic test_hold_timing;
    @(negedge clk);
    din  = 8'h11;
    load = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL hold_edge_k got %b exp 00", state); end
    @(posedge clk); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL hold_edge_k1 got %b exp 00", state); end
    @(posedge clk); #1;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL hold_edge_k2 got %b exp 01", state); end
    checks++; if (op_a !== 8'h11) begin errors++; $display("FAIL hold_op_a got %h exp 11", op_a); end
    din = 8'h22;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL hold_single got %b exp 01", state); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL hold_op_b got %h exp 00", op_b); end
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    // back to IDLE for the wrap test
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 255; i++) begin
      pulse_load(8'h01);
      pulse_load(8'h02);
    end
    checks++; if (pair_cnt !== 8'hFF) begin errors++; $display("FAIL wrap_pre got %h exp ff", pair_cnt); end
    pulse_load(8'h03);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_mid_valid got %b exp 0", valid); end
    pulse_load(8'h04);
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt got %h exp 00", pair_cnt); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", valid); end
    checks++; if (op_b !== 8'h04) begin errors++; $display("FAIL wrap_op_b got %h exp 04", op_b); end
  endtask

  task automatic test_ena_low;
    // READY, op_a=03, op_b=04, pair_cnt=0
    ena = 1'b0;
    pulse_load(8'hAB);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ena_state got %b exp 10", state); end
    checks++; if (op_a !== 8'h03) begin errors++; $display("FAIL ena_op_a got %h exp 03", op_a); end
    checks++; if (op_b !== 8'h04) begin errors++; $display("FAIL ena_op_b got %h exp 04", op_b); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ena_valid got %b exp 1", valid); end
    ena = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ena_clr_state got %b exp 00", state); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL ena_clr_op_b got %h exp 00", op_b); end
    ena = 1'b1;
  endtask

  task automatic test_async_reset;
    pulse_load(8'hC3);
    pulse_load(8'h3C);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL areset_pre got %b exp 10", state); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL areset_state got %b exp 00", state); end
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL areset_op_a got %h exp 00", op_a); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL areset_op_b got %h exp 00", op_b); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", valid); end
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL areset_cnt got %h exp 00", pair_cnt); end
    din  = 8'h77;
    load = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL held_load_state got %b exp 01", state); end
    checks++; if (op_a !== 8'h77) begin errors++; $display("FAIL held_load_op_a got %h exp 77", op_a); end
    checks++; if (pair_cnt !== 8'h00) begin errors++; $display("FAIL held_load_cnt got %h exp 00", pair_cnt); end
    load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_pair;
    test_restart;
    test_clr_priority;
    test_hold_timing;
    test_wrap;
    test_ena_low;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
